// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//
// Iterative RV32M divide/remainder unit for a pipelined core. One restoring
// radix-2 step is performed per cycle, so a normal operation takes XLEN
// cycles. Divide-by-zero and signed overflow bypass the iteration and complete
// in a single cycle. The unit raises busy so the hazard controller can stall
// the pipe. The result is held in DONE for as long as stall_M is high.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   divide/remainder op presented by the execute stage
//   op       in   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a        in   dividend (sampled when start is accepted)
//   b        in   divisor  (sampled when start is accepted)
//   flush_E  in   abort the operation; this has priority over start and stall_M
//   stall_M  in   hold the completed result in DONE
//   busy     out  stall request (combinational)
//   done     out  result valid (high only in DONE)
//   result   out  quotient or remainder (registered)
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush_E,
    input  logic            stall_M,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]      op_reg;
    logic [XLEN-1:0] quot_reg;      // holds the dividend and shifts in quotient bits
    logic [XLEN-1:0] rem_reg;       // partial remainder
    logic [XLEN-1:0] divisor_reg;
    logic [CW-1:0]   count_reg;
    logic            q_neg_reg;
    logic            r_neg_reg;
    logic [XLEN-1:0] result_reg;

    // ------------------------------------------------------------------
    // Operand decode for the accept cycle
    // ------------------------------------------------------------------
    logic            accept;
    logic            is_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, overflow, special;
    logic [XLEN-1:0] special_res;

    assign accept    = (state_reg == IDLE) && start && !flush_E;
    assign is_signed = ~op[0];
    assign a_neg     = is_signed & a[XLEN-1];
    assign b_neg     = is_signed & b[XLEN-1];
    assign a_mag     = a_neg ? (XLEN'(0) - a) : a;
    assign b_mag     = b_neg ? (XLEN'(0) - b) : b;
    assign div_zero  = (b == '0);
    assign overflow  = is_signed && (a == INT_MIN) && (b == '1);
    assign special   = div_zero | overflow;

    // Divide by zero: quotient all ones, remainder is the raw dividend.
    // Signed overflow: quotient INT_MIN, remainder zero.
    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = op[1] ? a : '1;
        else
            special_res = op[1] ? '0 : INT_MIN;
    end

    // ------------------------------------------------------------------
    // One restoring step: shift the next dividend bit into the remainder,
    // subtract the divisor if it fits. The trial value needs one extra bit
    // because the shifted remainder may reach 2*divisor-1.
    // ------------------------------------------------------------------
    logic [XLEN:0]   trial;
    logic            fits;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] quot_step;
    logic            last_step;
    logic [XLEN-1:0] final_q, final_r, final_res;

    assign trial     = {rem_reg, quot_reg[XLEN-1]};
    assign fits      = trial >= {1'b0, divisor_reg};
    assign diff      = trial[XLEN-1:0] - divisor_reg;
    assign rem_step  = fits ? diff : trial[XLEN-1:0];
    assign quot_step = {quot_reg[XLEN-2:0], fits};
    assign last_step = (count_reg == CW'(XLEN-1));

    assign final_q   = q_neg_reg ? (XLEN'(0) - quot_step) : quot_step;
    assign final_r   = r_neg_reg ? (XLEN'(0) - rem_step)  : rem_step;
    assign final_res = op_reg[1] ? final_r : final_q;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (flush_E) begin
            state_next = IDLE;
        end else begin
            unique case (state_reg)
                IDLE: if (start)     state_next = special ? DONE : RUN;
                RUN:  if (last_step) state_next = DONE;
                DONE: if (!stall_M)  state_next = IDLE;
                default:             state_next = IDLE;
            endcase
        end
    end

    // busy is gated by rst_n so that it is low during reset even with start high.
    assign busy   = rst_n && ((state_reg == RUN) || accept);
    assign done   = (state_reg == DONE);
    assign result = result_reg;

    // ------------------------------------------------------------------
    // Datapath. A flush in RUN freezes the datapath; the contents are
    // irrelevant because the next accept reloads every register.
    // result_reg is written only on entry to DONE, so it keeps its last
    // completed value otherwise.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg      <= '0;
            quot_reg    <= '0;
            rem_reg     <= '0;
            divisor_reg <= '0;
            count_reg   <= '0;
            q_neg_reg   <= 1'b0;
            r_neg_reg   <= 1'b0;
            result_reg  <= '0;
        end else if (accept) begin
            op_reg      <= op;
            quot_reg    <= a_mag;
            rem_reg     <= '0;
            divisor_reg <= b_mag;
            count_reg   <= '0;
            q_neg_reg   <= a_neg ^ b_neg;
            r_neg_reg   <= a_neg;
            if (special)
                result_reg <= special_res;
        end else if ((state_reg == RUN) && !flush_E) begin
            quot_reg  <= quot_step;
            rem_reg   <= rem_step;
            count_reg <= count_reg + CW'(1);
            if (last_step)
                result_reg <= final_res;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
//
// Self-checking bench for div_unit (XLEN = 32). Directed cases cover the
// documented examples. Random operations are checked against an arithmetic
// reference model. The bench also covers flush, stall/hold, asynchronous
// reset and back-to-back issue. Cycle 0 is the cycle in which start is
// presented. Outputs are sampled a few time units after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush_E;
    logic        stall_M;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    div_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .flush_E (flush_E),
        .stall_M (stall_M),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: RV32M semantics from plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int     xi;
        int     yi;
        longint sx;
        longint sy;
        xi = x;
        yi = y;
        sx = xi;
        sy = yi;
        if (y == 32'd0)
            return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
            return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            2'b00:   return 32'(sx / sy);
            2'b01:   return x / y;
            2'b10:   return 32'(sx % sy);
            default: return x % y;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) return 1;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation in the current cycle (cycle 0) and wait for done.
    // Returns the done cycle (-1 on timeout), the result, and whether busy
    // ever deviated from "high until done, low in the done cycle".
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output logic [31:0] res, output bit busy_bad);
        op       = o;
        a        = x;
        b        = y;
        start    = 1'b1;
        busy_bad = 1'b0;
        lat      = -1;
        res      = 32'hDEAD_BEEF;
        #1;
        if (busy !== 1'b1) busy_bad = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            a     = $urandom;   // operands must have been latched
            b     = $urandom;
            #1;
            if (done === 1'b1) begin
                lat = c;
                res = result;
                if (busy !== 1'b0) busy_bad = 1'b1;
                break;
            end
            if (busy !== 1'b1) busy_bad = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        start   = 1'b1;
        op      = 2'b01;
        a       = 32'd100;
        b       = 32'd7;
        flush_E = 1'b0;
        stall_M = 1'b0;
        #3;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++;
        if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 00000000", result); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        tick;
        tick;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got done=%b busy=%b want 0/0", done, busy);
        end
        $display("test_reset: done");
    endtask

    task automatic test_directed;
        logic [1:0]  t_op  [9] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00, 2'b10};
        logic [31:0] t_a   [9] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                   32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] t_b   [9] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0,
                                   32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] t_exp [9] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC,
                                   32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        int          t_lat [9] = '{33, 33, 33, 33, 33, 1, 1, 1, 1};
        int          lat;
        logic [31:0] res;
        bit          bb;
        for (int i = 0; i < 9; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], lat, res, bb);
            $display("directed %0d: op=%0d a=%h b=%h -> result=%h done_cycle=%0d", i, t_op[i], t_a[i], t_b[i], res, lat);
            checks++;
            if (lat != t_lat[i]) begin errors++; $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, t_lat[i]); end
            checks++;
            if (res !== t_exp[i]) begin errors++; $display("FAIL directed_result[%0d] got %h want %h", i, res, t_exp[i]); end
            checks++;
            if (bb) begin errors++; $display("FAIL directed_busy[%0d] got irregular busy want high until done", i); end
            tick;
            checks++;
            if (done !== 1'b0 || result !== t_exp[i]) begin
                errors++;
                $display("FAIL directed_hold[%0d] got done=%b result=%h want 0/%h", i, done, result, t_exp[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [1:0]  o;
        logic [31:0] x, y, exp_r;
        int          lat, exp_l;
        logic [31:0] res;
        bit          bb;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            case ($urandom_range(0, 7))
                0:       y = 32'd0;
                1:       begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2:       y = 32'($urandom_range(1, 20));
                3:       begin x = 32'($urandom_range(0, 50)); y = $urandom; end
                default: y = $urandom;
            endcase
            exp_r = ref_result(o, x, y);
            exp_l = ref_latency(o, x, y);
            run_op(o, x, y, lat, res, bb);
            $display("random %0d: op=%0d a=%h b=%h -> result=%h expect=%h cycle=%0d", i, o, x, y, res, exp_r, lat);
            checks++;
            if (res !== exp_r) begin errors++; $display("FAIL random_result[%0d] got %h want %h", i, res, exp_r); end
            checks++;
            if (lat != exp_l) begin errors++; $display("FAIL random_latency[%0d] got %0d want %0d", i, lat, exp_l); end
            checks++;
            if (bb) begin errors++; $display("FAIL random_busy[%0d] got irregular busy want high until done", i); end
            // Back-to-back: the next iteration issues in the cycle after DONE.
            tick;
        end
    endtask

    task automatic test_flush;
        int          lat;
        logic [31:0] res;
        bit          bb;
        run_op(2'b01, 32'd1000, 32'd3, lat, res, bb);
        tick;
        checks++;
        if (result !== 32'd333) begin errors++; $display("FAIL flush_setup got %h want %h", result, 32'd333); end
        // cycle 0: start DIVU 77/5
        op = 2'b01; a = 32'd77; b = 32'd5; start = 1'b1;
        tick;                 // cycle 1
        start = 1'b0;
        repeat (9) tick;      // cycle 10
        flush_E = 1'b1;
        #1;
        tick;                 // cycle 11
        flush_E = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL flush_abort got busy=%b done=%b want 0/0", busy, done);
        end
        checks++;
        if (result !== 32'd333) begin errors++; $display("FAIL flush_result_hold got %h want %h", result, 32'd333); end
        // New start in cycle 11 must finish in cycle 44 (33 cycles later).
        run_op(2'b01, 32'd77, 32'd5, lat, res, bb);
        $display("flush: restart result=%h done %0d cycles after restart", res, lat);
        checks++;
        if (lat != 33) begin errors++; $display("FAIL flush_restart_latency got %0d want 33", lat); end
        checks++;
        if (res !== 32'd15) begin errors++; $display("FAIL flush_restart_result got %h want %h", res, 32'd15); end
        tick;
    endtask

    task automatic test_stall;
        int          lat;
        logic [31:0] res;
        bit          bb;
        logic [31:0] exp_r;
        exp_r = ref_result(2'b10, 32'hFFFF_FF9C, 32'd7);   // REM -100 % 7 = -2
        run_op(2'b10, 32'hFFFF_FF9C, 32'd7, lat, res, bb);
        checks++;
        if (res !== exp_r || lat != 33) begin
            errors++;
            $display("FAIL stall_setup got result=%h cycle=%0d want %h/33", res, lat, exp_r);
        end
        // DONE cycle 33: hold stall, present a start that must be ignored.
        stall_M = 1'b1;
        start   = 1'b1;
        op      = 2'b01;
        a       = 32'd9;
        b       = 32'd3;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy_in_done got %b want 0", busy); end
        for (int k = 1; k <= 3; k++) begin
            tick;                                // cycles 34, 35, 36
            if (k == 3) stall_M = 1'b0;
            #1;
            checks++;
            if (done !== 1'b1 || result !== exp_r || busy !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d] got done=%b result=%h busy=%b want 1/%h/0", k, done, result, busy, exp_r);
            end
        end
        tick;                                    // cycle 37: IDLE
        start = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== exp_r) begin
            errors++;
            $display("FAIL stall_release got done=%b busy=%b result=%h want 0/0/%h", done, busy, result, exp_r);
        end
        tick;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_ignored_start got done=%b busy=%b want 0/0", done, busy);
        end
        $display("stall: result held %h through stall", exp_r);
    endtask

    task automatic test_async_reset;
        int          lat;
        logic [31:0] res;
        bit          bb;
        run_op(2'b01, 32'd100, 32'd7, lat, res, bb);
        tick;
        op = 2'b01; a = 32'd5000; b = 32'd9; start = 1'b1;
        tick;                    // cycle 1
        start = 1'b0;
        repeat (14) tick;        // cycle 15
        start = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL async_reset got done=%b result=%h want 0/00000000", done, result);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got %b want 0", busy); end
        tick;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_idle got done=%b busy=%b want 0/0", done, busy);
        end
        run_op(2'b11, 32'd100, 32'd7, lat, res, bb);
        $display("async_reset: post-reset REMU result=%h cycle=%0d", res, lat);
        checks++;
        if (res !== 32'd2 || lat != 33) begin
            errors++;
            $display("FAIL async_reset_resume got result=%h cycle=%0d want 00000002/33", res, lat);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_flush;
        test_stall;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand and result width.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  execute stage presents a divide/remainder op this cycle.
REQ-005 SHALL have port: op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M encoding order).
REQ-006 SHALL have port: a  input  XLEN  dividend, sampled on accepted start.
REQ-007 SHALL have port: b  input  XLEN  divisor, sampled on accepted start.
REQ-008 SHALL have port: flush_E  input  1  flush from hazard controller; aborts the operation.
REQ-009 SHALL have port: stall_M  input  1  stall from hazard controller; holds the completed result.
REQ-010 SHALL have port: busy  output  1  stall request to hazard controller, combinational.
REQ-011 SHALL have port: done  output  1  result valid.
REQ-012 SHALL have port: result  output  XLEN  quotient or remainder, registered.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL accept start only in IDLE with flush_E low; starts arriving in RUN or DONE are ignored.
REQ-015 SHALL on accept latch op and operand magnitudes (|a|, |b| for signed ops) and quotient/remainder sign flags.
REQ-016 SHALL go IDLE->RUN on accept with a normal operand pair, iterating one restoring radix-2 step per cycle for exactly XLEN cycles.
REQ-017 SHALL go RUN->DONE after the XLEN-th step; with start in cycle 0, done = 1 in cycle XLEN+1 (cycle 33 at XLEN=32).
REQ-018 SHALL short-circuit divide by zero (b = 0): go IDLE->DONE directly (done in cycle 1); quotient all ones, remainder a.
REQ-019 SHALL short-circuit signed overflow (DIV/REM, a = 0x80000000, b = 0xFFFFFFFF): go IDLE->DONE directly; quotient 0x80000000, remainder 0.
REQ-020 SHALL negate the quotient when the signs of a and b differ (signed ops only) and give the remainder the sign of a.
REQ-021 SHALL drive busy = (state==RUN) | (state==IDLE & start & !flush_E); busy is low in DONE.
REQ-022 SHALL assert done and hold result only in DONE; DONE->IDLE when stall_M is low, else remain in DONE holding done and result.
REQ-023 SHALL keep result stable at its last completed value outside DONE.
REQ-024 SHALL on flush_E high in any state go to IDLE next cycle with done low; flush_E takes priority over start and stall_M in the same cycle.
REQ-025 SHALL accept a new start in the cycle after returning to IDLE; no back-to-back accept in the DONE cycle.

Reset
REQ-026 SHALL on rst_n low immediately force state IDLE, done 0, result 0, and all internal quotient/remainder/count registers 0, including mid-operation.
REQ-027 SHALL drive busy 0 while rst_n is low, regardless of start.
REQ-028 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-029 SHALL verify DIVU a=100 b=7 start in cycle 0 -> busy cycles 0-32, done in cycle 33 with result 14; REMU -> result 2.
REQ-030 SHALL verify DIV a=-7 b=2 -> result 0xFFFFFFFD; REM -> result 0xFFFFFFFF; DIVU a=0xFFFFFFF9 b=2 -> result 0x7FFFFFFC.
REQ-031 SHALL verify DIVU a=5 b=0 -> done in cycle 1 with result 0xFFFFFFFF; REMU -> result 5; DIV a=0x80000000 b=0xFFFFFFFF -> result 0x80000000, REM -> result 0.
REQ-032 SHALL verify flush_E pulsed in cycle 10 of a DIVU -> busy 0 from cycle 11, no done ever, result unchanged; a new start in cycle 11 completes in cycle 44.
REQ-033 SHALL verify stall_M held high for 3 cycles at completion -> done and result stable for 4 cycles, then IDLE; start asserted during DONE is ignored.
REQ-034 SHALL verify rst_n asserted in cycle 15 of an operation -> state IDLE, done 0, result 0 asynchronously; the next start after release completes normally.
